// File: rtl/alu16_sequencer.sv
// Two-pass 16-bit ADD16/ADDSP/INC16/DEC16 on the shared 8-bit ALU; accept at edge k, done pulse k+3..k+4.
// No backpressure: start is taken only in IDLE and dropped otherwise; the ALU is owned only during LO and HI.
module alu16_sequencer #(
   parameter int                  ALU_OP_W = 5,
   parameter logic [ALU_OP_W-1:0] OP_NOP   = ALU_OP_W'(0),
   parameter logic [ALU_OP_W-1:0] OP_ADD   = ALU_OP_W'(1),
   parameter logic [ALU_OP_W-1:0] OP_ADC   = ALU_OP_W'(2),
   parameter logic [ALU_OP_W-1:0] OP_SUB   = ALU_OP_W'(3),
   parameter logic [ALU_OP_W-1:0] OP_SBC   = ALU_OP_W'(4),
   parameter int                  FLAG_Z   = 3,
   parameter int                  FLAG_N   = 2,
   parameter int                  FLAG_H   = 1,
   parameter int                  FLAG_C   = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [15:0]         opa,
   input  logic [15:0]         opb,
   input  logic [3:0]          flags_in,
   output logic                busy,
   output logic                done,
   output logic [15:0]         result,
   output logic [3:0]          flags_out,
   output logic                alu_own,
   output logic [7:0]          alu_a,
   output logic [7:0]          alu_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [3:0]          alu_flags_in,
   input  logic [7:0]          alu_res,
   input  logic [3:0]          alu_flags_out
);

   localparam logic [1:0] OP16_ADD = 2'd0;
   localparam logic [1:0] OP16_ASP = 2'd1;
   localparam logic [1:0] OP16_INC = 2'd2;
   localparam logic [1:0] OP16_DEC = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t                state_q;
   logic [1:0]            op_q;
   logic [15:0]           opa_q;
   logic [15:0]           opb_q;
   logic [3:0]            fin_q;
   logic [7:0]            res_lo_q;
   logic                  c_lo_q;
   logic                  h_lo_q;
   logic                  busy_q;
   logic                  done_q;
   logic [15:0]           result_q;
   logic [3:0]            flags_q;
   logic [7:0]            alu_a_q;
   logic [7:0]            alu_b_q;
   logic [ALU_OP_W-1:0]   alu_op_q;
   logic [3:0]            alu_fin_q;

   logic [4:0]            nib_lo_sum;
   logic [4:0]            nib_hi_sum;
   logic                  h_lo_d;
   logic                  h_hi_d;
   logic [7:0]            lo_b_d;
   logic [ALU_OP_W-1:0]   lo_op_d;
   logic [7:0]            hi_b_d;
   logic [ALU_OP_W-1:0]   hi_op_d;
   logic [3:0]            hi_cin_d;
   logic [3:0]            flags_d;

   // Half carries are formed here because the ALU H bit reflects only one byte.
   assign nib_lo_sum = {1'b0, opa_q[3:0]} + {1'b0, opb_q[3:0]};
   assign nib_hi_sum = {1'b0, opa_q[11:8]} + {1'b0, opb_q[11:8]} + {4'b0000, c_lo_q};
   assign h_lo_d     = nib_lo_sum[4];
   assign h_hi_d     = nib_hi_sum[4];

   always_comb begin
      lo_b_d  = opb[7:0];
      lo_op_d = OP_ADD;
      if (op == OP16_INC || op == OP16_DEC) begin
         lo_b_d = 8'h01;
      end
      if (op == OP16_DEC) begin
         lo_op_d = OP_SUB;
      end
   end

   always_comb begin
      hi_b_d   = 8'h00;
      hi_op_d  = OP_ADC;
      hi_cin_d = 4'b0000;
      hi_cin_d[FLAG_C] = alu_flags_out[FLAG_C];
      case (op_q)
         OP16_ADD: hi_b_d = opb_q[15:8];
         OP16_ASP: hi_b_d = {8{opb_q[7]}};
         OP16_DEC: hi_op_d = OP_SBC;
         default:  hi_b_d = 8'h00;
      endcase
   end

   always_comb begin
      flags_d = fin_q;
      case (op_q)
         OP16_ADD: begin
            flags_d[FLAG_N] = 1'b0;
            flags_d[FLAG_H] = h_hi_d;
            flags_d[FLAG_C] = alu_flags_out[FLAG_C];
         end
         OP16_ASP: begin
            flags_d         = 4'b0000;
            flags_d[FLAG_H] = h_lo_q;
            flags_d[FLAG_C] = c_lo_q;
         end
         default: flags_d = fin_q;
      endcase
   end

   // done is registered off the DONE state, so it lands one cycle after DONE while the FSM is back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= 2'd0;
         opa_q     <= 16'h0000;
         opb_q     <= 16'h0000;
         fin_q     <= 4'b0000;
         res_lo_q  <= 8'h00;
         c_lo_q    <= 1'b0;
         h_lo_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= 16'h0000;
         flags_q   <= 4'b0000;
         alu_a_q   <= 8'h00;
         alu_b_q   <= 8'h00;
         alu_op_q  <= OP_NOP;
         alu_fin_q <= 4'b0000;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_LO;
                  op_q      <= op;
                  opa_q     <= opa;
                  opb_q     <= opb;
                  fin_q     <= flags_in;
                  busy_q    <= 1'b1;
                  alu_a_q   <= opa[7:0];
                  alu_b_q   <= lo_b_d;
                  alu_op_q  <= lo_op_d;
                  alu_fin_q <= 4'b0000;
               end
            end
            S_LO: begin
               state_q   <= S_HI;
               res_lo_q  <= alu_res;
               c_lo_q    <= alu_flags_out[FLAG_C];
               h_lo_q    <= h_lo_d;
               alu_a_q   <= opa_q[15:8];
               alu_b_q   <= hi_b_d;
               alu_op_q  <= hi_op_d;
               alu_fin_q <= hi_cin_d;
            end
            S_HI: begin
               state_q   <= S_DONE;
               busy_q    <= 1'b0;
               result_q  <= {alu_res, res_lo_q};
               flags_q   <= flags_d;
               alu_a_q   <= 8'h00;
               alu_b_q   <= 8'h00;
               alu_op_q  <= OP_NOP;
               alu_fin_q <= 4'b0000;
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b1;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign alu_own      = busy_q;
   assign done         = done_q;
   assign result       = result_q;
   assign flags_out    = flags_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign alu_flags_in = alu_fin_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a behavioural 8-bit ALU attached.
module tb_alu16_sequencer;

   localparam logic [4:0] NOP = 5'd0;
   localparam logic [4:0] ADD = 5'd1;
   localparam logic [4:0] ADC = 5'd2;
   localparam logic [4:0] SUB = 5'd3;
   localparam logic [4:0] SBC = 5'd4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [3:0]  flags_in;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [3:0]  flags_out;
   logic        alu_own;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [4:0]  alu_op;
   logic [3:0]  alu_flags_in;
   logic [7:0]  alu_res;
   logic [3:0]  alu_flags_out;
   logic [8:0]  alu_s;

   int total = 0;
   int bad   = 0;

   logic [15:0] r_res;
   logic [3:0]  r_flg;
   logic [4:0]  r_lo_op;
   logic [4:0]  r_hi_op;
   logic [3:0]  r_hi_fin;
   logic        r_done_after;
   int          r_lat;

   always #5 clk = ~clk;

   alu16_sequencer #(.ALU_OP_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
      .flags_in(flags_in), .busy(busy), .done(done), .result(result),
      .flags_out(flags_out), .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_flags_in(alu_flags_in), .alu_res(alu_res),
      .alu_flags_out(alu_flags_out)
   );

   // Reference ALU: flags {Z,N,H,C}; H is deliberately bogus so the DUT must not rely on it.
   always_comb begin
      alu_s = 9'h000;
      case (alu_op)
         ADD: alu_s = {1'b0, alu_a} + {1'b0, alu_b};
         ADC: alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_flags_in[0]};
         SUB: alu_s = {1'b0, alu_a} - {1'b0, alu_b};
         SBC: alu_s = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_flags_in[0]};
         default: alu_s = 9'h000;
      endcase
      alu_res       = alu_s[7:0];
      alu_flags_out = {alu_s[7:0] == 8'h00, (alu_op == SUB || alu_op == SBC), 1'b1, alu_s[8]};
   end

   task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f);
      @(negedge clk);
      op = o; opa = a; opb = b; flags_in = f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; opa = ~a; opb = ~b; flags_in = ~f; op = ~o;
      r_lo_op = alu_op;
      r_hi_op = NOP;
      r_hi_fin = 4'b0000;
      r_lat = -1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            r_hi_op  = alu_op;
            r_hi_fin = alu_flags_in;
         end
         if (done) begin
            r_lat = i;
            break;
         end
      end
      r_res = result;
      r_flg = flags_out;
      @(posedge clk); #1;
      r_done_after = done;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; op = 2'd0; opa = 16'h0; opb = 16'h0; flags_in = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", result); end
      total++; if (flags_out !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_out); end
      total++; if (alu_op !== NOP) begin bad++; $display("FAIL reset_alu_op got=%0d exp=%0d", alu_op, NOP); end
      total++; if ({alu_own, alu_a, alu_b, alu_flags_in} !== 21'h0) begin bad++;
         $display("FAIL reset_alu_bus got=%b/%h/%h/%b exp=0", alu_own, alu_a, alu_b, alu_flags_in); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_add16;
      run_op(2'd0, 16'h0FFF, 16'h0001, 4'b1101);
      total++; if (r_lat !== 3) begin bad++; $display("FAIL add16_latency got=%0d exp=3", r_lat); end
      total++; if (r_res !== 16'h1000) begin bad++; $display("FAIL add16_a_result got=%h exp=1000", r_res); end
      total++; if (r_flg !== 4'b1010) begin bad++; $display("FAIL add16_a_flags got=%b exp=1010", r_flg); end
      total++; if (r_hi_fin !== 4'b0001) begin bad++; $display("FAIL add16_hi_carry_in got=%b exp=0001", r_hi_fin); end
      total++; if (r_done_after !== 1'b0) begin bad++; $display("FAIL add16_done_width got=%b exp=0", r_done_after); end
      run_op(2'd0, 16'h8000, 16'h8000, 4'b0000);
      total++; if (r_res !== 16'h0000) begin bad++; $display("FAIL add16_b_result got=%h exp=0000", r_res); end
      total++; if (r_flg !== 4'b0001) begin bad++; $display("FAIL add16_b_flags got=%b exp=0001", r_flg); end
   endtask

   task automatic test_addsp;
      run_op(2'd1, 16'h00FF, 16'h5501, 4'b1111);
      total++; if (r_res !== 16'h0100) begin bad++; $display("FAIL addsp_a_result got=%h exp=0100", r_res); end
      total++; if (r_flg !== 4'b0011) begin bad++; $display("FAIL addsp_a_flags got=%b exp=0011", r_flg); end
      run_op(2'd1, 16'h1000, 16'hABFE, 4'b1111);
      total++; if (r_res !== 16'h0FFE) begin bad++; $display("FAIL addsp_b_result got=%h exp=0ffe", r_res); end
      total++; if (r_flg !== 4'b0000) begin bad++; $display("FAIL addsp_b_flags got=%b exp=0000", r_flg); end
   endtask

   task automatic test_incdec;
      run_op(2'd2, 16'hFFFF, 16'h1234, 4'b0101);
      total++; if (r_res !== 16'h0000) begin bad++; $display("FAIL inc_result got=%h exp=0000", r_res); end
      total++; if (r_flg !== 4'b0101) begin bad++; $display("FAIL inc_flags got=%b exp=0101", r_flg); end
      total++; if (r_lo_op !== ADD) begin bad++; $display("FAIL inc_lo_op got=%0d exp=%0d", r_lo_op, ADD); end
      total++; if (r_hi_op !== ADC) begin bad++; $display("FAIL inc_hi_op got=%0d exp=%0d", r_hi_op, ADC); end
      run_op(2'd3, 16'h0000, 16'h1234, 4'b1010);
      total++; if (r_res !== 16'hFFFF) begin bad++; $display("FAIL dec_result got=%h exp=ffff", r_res); end
      total++; if (r_flg !== 4'b1010) begin bad++; $display("FAIL dec_flags got=%b exp=1010", r_flg); end
      total++; if (r_lo_op !== SUB) begin bad++; $display("FAIL dec_lo_op got=%0d exp=%0d", r_lo_op, SUB); end
      total++; if (r_hi_op !== SBC) begin bad++; $display("FAIL dec_hi_op got=%0d exp=%0d", r_hi_op, SBC); end
   endtask

   task automatic test_back_to_back;
      int busy_cyc, busy_rise, done_cyc, done_rise, own_diff;
      logic busy_prev, done_prev;
      busy_cyc = 0; busy_rise = 0; done_cyc = 0; done_rise = 0; own_diff = 0;
      busy_prev = 1'b0; done_prev = 1'b0;
      @(negedge clk);
      op = 2'd0; opa = 16'h0FFF; opb = 16'h0001; flags_in = 4'b1000; start = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (i == 6) start = 1'b0;
         if (busy !== alu_own) own_diff++;
         if (busy === 1'b1) busy_cyc++;
         if (busy === 1'b1 && busy_prev === 1'b0) busy_rise++;
         if (done === 1'b1) done_cyc++;
         if (done === 1'b1 && done_prev === 1'b0) done_rise++;
         busy_prev = busy;
         done_prev = done;
      end
      total++; if (busy_rise !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", busy_rise); end
      total++; if (busy_cyc !== 4) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=4", busy_cyc); end
      total++; if (done_rise !== 2 || done_cyc !== 2) begin bad++;
         $display("FAIL b2b_done_pulses got=%0d/%0d cycles exp=2/2", done_rise, done_cyc); end
      total++; if (own_diff !== 0) begin bad++; $display("FAIL b2b_alu_own got=%0d diffs exp=0", own_diff); end
      total++; if (result !== 16'h1000) begin bad++; $display("FAIL b2b_result got=%h exp=1000", result); end
   endtask

   task automatic test_reset_mid_op;
      int stray;
      stray = 0;
      @(negedge clk);
      op = 2'd2; opa = 16'h1234; opb = 16'h0; flags_in = 4'b1111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_in_lo got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || alu_own !== 1'b0) begin bad++;
         $display("FAIL midrst_busy got=%b/%b exp=0/0", busy, alu_own); end
      total++; if (result !== 16'h0000 || flags_out !== 4'h0) begin bad++;
         $display("FAIL midrst_result got=%h/%b exp=0000/0000", result, flags_out); end
      total++; if (alu_op !== NOP) begin bad++; $display("FAIL midrst_alu_op got=%0d exp=%0d", alu_op, NOP); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      total++; if (stray !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d active cycles exp=0", stray); end
   endtask

   initial begin
      test_reset;
      test_add16;
      test_addsp;
      test_incdec;
      test_back_to_back;
      test_reset_mid_op;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
